// File: rtl/hazard_fwd_unit.sv
// Purpose: decode-side RAW hazard detector with ALU operand forwarding select and stall counter.
// Latency: zero-cycle decision; outputs are combinational from shadow EX/MEM state plus ID inputs.
// Backpressure: holds PC and IF/ID (pc_en=0) and injects an ID/EX bubble while stalling; flush wins.
module hazard_fwd_unit #(
    parameter int RA_W   = 2,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [3:0]       id_op,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             flush,
    output logic             pc_en,
    output logic             id_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);

    // Shadow copy of the destination info of the instructions in EX and MEM.
    logic            ex_v, ex_wr, ex_ld;
    logic [RA_W-1:0] ex_rd;
    logic            mem_v, mem_wr, mem_ld;
    logic [RA_W-1:0] mem_rd;

    logic id_wr, id_ld;
    logic m_ex_1, m_ex_2, m_mem_1, m_mem_2;
    logic raw_stall, stall;

    // Opcode decode: which ID instructions write a register, and which are loads.
    always_comb begin
        id_wr = 1'b0;
        case (id_op)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
            4'h7, 4'h8, 4'hD, 4'hF: id_wr = 1'b1;
            default:                id_wr = 1'b0;
        endcase
        id_ld = (id_op == 4'hD);
    end

    // Source/destination matches against the two in-flight producers (r0 included).
    always_comb begin
        m_ex_1  = ex_v  & ex_wr  & (ex_rd  == id_rs1) & id_use1;
        m_ex_2  = ex_v  & ex_wr  & (ex_rd  == id_rs2) & id_use2;
        m_mem_1 = mem_v & mem_wr & (mem_rd == id_rs1) & id_use1;
        m_mem_2 = mem_v & mem_wr & (mem_rd == id_rs2) & id_use2;
    end

    // Stall decision: load-use only with forwarding, any EX/MEM RAW without; flush cancels it.
    always_comb begin
        if (FWD_EN != 0) begin
            raw_stall = id_valid & ex_ld & (m_ex_1 | m_ex_2);
        end else begin
            raw_stall = id_valid & (m_ex_1 | m_ex_2 | m_mem_1 | m_mem_2);
        end
        stall     = raw_stall & ~flush;
        pc_en     = ~stall;
        id_bubble = stall | flush | ~id_valid;
    end

    // Forwarding select: youngest producer first; a load in EX has no result yet.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (FWD_EN != 0) begin
            if (m_ex_1 & ~ex_ld) begin
                fwd_a = 2'b01;
            end else if (m_mem_1) begin
                fwd_a = 2'b10;
            end
            if (m_ex_2 & ~ex_ld) begin
                fwd_b = 2'b01;
            end else if (m_mem_2) begin
                fwd_b = 2'b10;
            end
        end
    end

    // Shadow pipeline advance: MEM follows EX, EX takes the ID instruction or a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v   <= 1'b0;
            ex_wr  <= 1'b0;
            ex_ld  <= 1'b0;
            ex_rd  <= '0;
            mem_v  <= 1'b0;
            mem_wr <= 1'b0;
            mem_ld <= 1'b0;
            mem_rd <= '0;
        end else begin
            mem_v  <= ex_v;
            mem_wr <= ex_wr;
            mem_ld <= ex_ld;
            mem_rd <= ex_rd;
            if (id_valid & ~stall & ~flush) begin
                ex_v  <= 1'b1;
                ex_wr <= id_wr;
                ex_ld <= id_ld;
                ex_rd <= id_rd;
            end else begin
                ex_v  <= 1'b0;
            end
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Parametrised successor to the single-register-pair bubble checker.
- Tracks the destinations of the instructions in the EX and MEM stages in its own shadow pipeline.
- Decides per cycle whether the ID-stage instruction must stall, and which forwarding source each ALU operand takes.
- Supports a no-forwarding mode, branch flush and a saturating stall counter. Sits beside the decode stage and drives the PC write enable and the ID/EX bubble insertion.

Parameters:
- RA_W, 2, register address width (2**RA_W architectural registers).
- FWD_EN, 1, 1 = forwarding with load-use stall only; 0 = stall on any RAW against EX or MEM.
- CNT_W, 16, stall counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_op  input  4  opcode of ID instruction (bits [7:4] of instruction).
- id_rs1  input  RA_W  first source register.
- id_rs2  input  RA_W  second source register.
- id_use1  input  1  ID instruction reads rs1.
- id_use2  input  1  ID instruction reads rs2.
- id_rd  input  RA_W  destination register.
- flush  input  1  taken branch/jump resolved this cycle; kill ID instruction.
- pc_en  output  1  PC and IF/ID register write enable.
- id_bubble  output  1  load a NOP into ID/EX this cycle.
- fwd_a  output  2  operand A source: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB writeback data.
- fwd_b  output  2  operand B source, same encoding.
- stall_cnt  output  CNT_W  number of stall cycles since reset, saturating.

Behaviour:
- Writer decode: wr = op in {1,2,3,4,5,7,8,D,F}. Load decode: ld = (op == D).
- Shadow stages: EX{v,rd,wr,ld} and MEM{v,rd,wr,ld}. Every rising edge, MEM <= EX.
- EX <= ID fields with v=1 when id_valid & ~stall & ~flush; otherwise EX.v <= 0 (bubble).
- Match: mX_s = X.v & X.wr & (X.rd == id_rsN) & id_useN, for X in {EX, MEM} and s in {1, 2}.
- Stall, FWD_EN=1: stall = id_valid & EX.ld & (mEX_1 | mEX_2). Exactly one cycle per load-use, because the next cycle the load sits in MEM and is forwarded.
- Stall, FWD_EN=0: stall = id_valid & (mEX_1 | mEX_2 | mMEM_1 | mMEM_2). Up to 2 cycles; the regfile is write-before-read in WB, so no WB check.
- flush overrides stall: stall is forced to 0 when flush=1, so id_bubble=1 and pc_en=1.
- pc_en = ~stall. id_bubble = stall | flush | ~id_valid.
- Forwarding, FWD_EN=1: fwd_a = 01 if mEX_1 & ~EX.ld; else 10 if mMEM_1; else 00. fwd_b is the same using rs2.
  - The youngest producer (EX) has priority.
  - fwd_* are don't-care while stall=1 but must still be driven deterministically by the same equations.
- Forwarding, FWD_EN=0: fwd_a = fwd_b = 00 always.
- Output timing: all outputs are combinational from registered state plus ID inputs, giving zero-cycle decision latency.
- stall_cnt increments on every edge where stall=1 and holds at 2**CNT_W-1 when saturated.
- Reset, asynchronous assert: EX.v = MEM.v = 0 and stall_cnt = 0. Outputs then read pc_en=1, fwd_a=fwd_b=00, and id_bubble = ~id_valid.
- Reset mid-stall: the stall drops immediately with rst_n, and there is no residual stall after release.
- Reset release is synchronous to clk in the surrounding design; the block needs no extra handling.
- Register 0 has no special treatment; it is hazard-checked like any other register.

Test Plan:
- Reset: rst_n=0 with id_valid=1 and op=1 -> pc_en=1, fwd_a=fwd_b=00, stall_cnt=0; hold 3 cycles, no change.
- Back-to-back ALU, FWD_EN=1: ADD r1 then ADD r2,r1,r1 -> no stall, fwd_a=fwd_b=01. Next instruction SUB r3,r1 -> fwd_a=10.
- Load-use, FWD_EN=1: LOAD r2 then ADD r0,r2 -> stall exactly 1 cycle (pc_en=0, id_bubble=1), then fwd_a=10; stall_cnt=1.
- No-forward mode, FWD_EN=0: ADD r1 then SHL r1,r1 -> 2 stall cycles, fwd=00 throughout, stall_cnt=2.
- Flush during stall: load-use pending and flush=1 in the same cycle -> pc_en=1, id_bubble=1; next cycle EX.v=0 and no stall.
- Saturation, CNT_W=4: force 20 stall cycles -> stall_cnt stops at 15. An async reset pulse mid-stall -> stall_cnt=0 and pc_en=1 immediately.
